// File: rtl/mips16_pkg.sv
// mips16_pkg: shared widths, ALU opcodes and forwarding-select codes for the 16-bit MIPS core.
package mips16_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use hazard detect, next-cycle forwarding selects and write-back bypass selects.
module hazard_fwd_unit
  import mips16_pkg::*;
#(
  parameter int RW = 3
) (
  input  logic          valid_id,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic          uses_rt,
  input  logic          ex_valid,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_write_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_write_reg,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_write_reg,
  output logic          haz,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          byp_a,
  output logic          byp_b
);
  logic ex_w, mem_w;
  // The instruction now in EX becomes EX/MEM next cycle; EX/MEM becomes MEM/WB.
  always_comb begin
    ex_w  = ex_valid & ex_reg_write & (ex_write_reg != '0);
    mem_w = exmem_reg_write & (exmem_write_reg != '0);
    haz   = valid_id & ex_valid & ex_mem_read & ex_reg_write & (ex_write_reg != '0) &
            ((ex_write_reg == rs) | (uses_rt & (ex_write_reg == rt)));
    fwd_a = (ex_w & ex_write_reg == rs) ? FWD_EXMEM :
            (mem_w & exmem_write_reg == rs) ? FWD_MEMWB : FWD_REG;
    fwd_b = (ex_w & ex_write_reg == rt) ? FWD_EXMEM :
            (mem_w & exmem_write_reg == rt) ? FWD_MEMWB : FWD_REG;
    byp_a = wb_reg_write & (wb_write_reg == rs) & (rs != '0);
    byp_b = wb_reg_write & (wb_write_reg == rt) & (rt != '0);
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbling, registered forwarding selects
// and a saturating bubble counter.
module id_ex_stage
  import mips16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int IMM_W  = 6,
  parameter int CTL_W  = 3
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic              i_Valid_ID,
  input  logic [REG_W-1:0]  i_Rs,
  input  logic [REG_W-1:0]  i_Rt,
  input  logic [REG_W-1:0]  i_Rd,
  input  logic              i_Uses_Rt,
  input  logic [DATA_W-1:0] i_Read_Data_1,
  input  logic [DATA_W-1:0] i_Read_Data_2,
  input  logic [IMM_W-1:0]  i_Imm,
  input  logic [CTL_W-1:0]  i_ALU_Control,
  input  logic              i_ALU_Src,
  input  logic              i_Reg_Dst,
  input  logic              i_Reg_Write,
  input  logic              i_Mem_Read,
  input  logic              i_Mem_Write,
  input  logic              i_Mem_To_Reg,
  input  logic              i_ExMem_Reg_Write,
  input  logic [REG_W-1:0]  i_ExMem_Write_Reg,
  input  logic              i_WB_Reg_Write,
  input  logic [REG_W-1:0]  i_WB_Write_Reg,
  input  logic [DATA_W-1:0] i_WB_Data,
  input  logic              i_Flush,
  input  logic              i_Hold,
  output logic              o_Stall,
  output logic              o_Valid,
  output logic [DATA_W-1:0] o_A,
  output logic [DATA_W-1:0] o_B,
  output logic [DATA_W-1:0] o_Imm_Ext,
  output logic [CTL_W-1:0]  o_ALU_Control,
  output logic              o_ALU_Src,
  output logic              o_Reg_Write,
  output logic              o_Mem_Read,
  output logic              o_Mem_Write,
  output logic              o_Mem_To_Reg,
  output logic [REG_W-1:0]  o_Write_Reg,
  output logic [1:0]        o_Fwd_A,
  output logic [1:0]        o_Fwd_B,
  output logic [15:0]       o_Bubble_Count
);
  logic       haz, byp_a, byp_b, ld, v, inc;
  logic [1:0] fwd_a, fwd_b;
  hazard_fwd_unit #(.RW(REG_W)) u_hfu (
    .valid_id        (i_Valid_ID),
    .rs              (i_Rs),
    .rt              (i_Rt),
    .uses_rt         (i_Uses_Rt),
    .ex_valid        (o_Valid),
    .ex_reg_write    (o_Reg_Write),
    .ex_mem_read     (o_Mem_Read),
    .ex_write_reg    (o_Write_Reg),
    .exmem_reg_write (i_ExMem_Reg_Write),
    .exmem_write_reg (i_ExMem_Write_Reg),
    .wb_reg_write    (i_WB_Reg_Write),
    .wb_write_reg    (i_WB_Write_Reg),
    .haz             (haz),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .byp_a           (byp_a),
    .byp_b           (byp_b)
  );
  // A bubble is every field cleared; a non-valid ID instruction loads with its control cleared.
  always_comb begin
    ld      = ~i_Flush & ~haz;
    v       = ld & i_Valid_ID;
    inc     = ~i_Flush & haz & ~&o_Bubble_Count;
    o_Stall = i_Hold | (haz & ~i_Flush);
  end
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Valid        <= 1'b0;
      o_A            <= '0;
      o_B            <= '0;
      o_Imm_Ext      <= '0;
      o_ALU_Control  <= '0;
      o_ALU_Src      <= 1'b0;
      o_Reg_Write    <= 1'b0;
      o_Mem_Read     <= 1'b0;
      o_Mem_Write    <= 1'b0;
      o_Mem_To_Reg   <= 1'b0;
      o_Write_Reg    <= '0;
      o_Fwd_A        <= FWD_REG;
      o_Fwd_B        <= FWD_REG;
      o_Bubble_Count <= '0;
    end else if (!i_Hold) begin
      o_Valid        <= v;
      o_A            <= ld ? (byp_a ? i_WB_Data : i_Read_Data_1) : '0;
      o_B            <= ld ? (byp_b ? i_WB_Data : i_Read_Data_2) : '0;
      o_Imm_Ext      <= ld ? {{(DATA_W-IMM_W){i_Imm[IMM_W-1]}}, i_Imm} : '0;
      o_ALU_Control  <= ld ? i_ALU_Control : '0;
      o_ALU_Src      <= v & i_ALU_Src;
      o_Reg_Write    <= v & i_Reg_Write;
      o_Mem_Read     <= v & i_Mem_Read;
      o_Mem_Write    <= v & i_Mem_Write;
      o_Mem_To_Reg   <= v & i_Mem_To_Reg;
      o_Write_Reg    <= ld ? (i_Reg_Dst ? i_Rd : i_Rt) : '0;
      o_Fwd_A        <= v ? fwd_a : FWD_REG;
      o_Fwd_B        <= v ? fwd_b : FWD_REG;
      o_Bubble_Count <= o_Bubble_Count + {15'd0, inc};
    end
  end
endmodule
